main_memory: RTL and testbench

//   Single-port word-addressed main memory model for the CPU memory subsystem.

---
 rtl/mem_pkg.sv | 9 +
 rtl/main_memory_if.sv | 11 +
 rtl/mem_array.sv | 22 ++
 rtl/main_memory.sv | 48 ++++
 tb/tb_main_memory.sv | 114 +++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared sizing and mode encodings for the main memory model.
package mem_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4096;
  localparam int IDX_W  = $clog2(DEPTH);
  localparam logic MODE_READ  = 1'b0;
  localparam logic MODE_WRITE = 1'b1;
endpackage

// File: rtl/main_memory_if.sv
// main_memory_if: request/response bus between the datapath and main memory.
interface main_memory_if;
  import mem_pkg::*;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] input_data;
  logic              mode;
  logic [DATA_W-1:0] output_data;
  logic              flag;
  modport master (output addr, input_data, mode, input output_data, flag);
  modport slave (input addr, input_data, mode, output output_data, flag);
endinterface

// File: rtl/mem_array.sv
// mem_array: DEPTH x DATA_W storage, synchronous write, registered read, no reset.
module mem_array
  import mem_pkg::*;
#(
  parameter int DW = DATA_W,
  parameter int IW = IDX_W
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [IW-1:0] idx_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [2**IW];
  logic [DW-1:0] rdata_q;
  always_ff @(posedge clk) begin
    if (we_i) mem_q[idx_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[idx_i];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/main_memory.sv
// main_memory: word-addressed backing store with per-entry valid bits and
// registered read data / status flag.
module main_memory
  import mem_pkg::*;
(
  input logic          clk,
  input logic          rst_n,
  main_memory_if.slave bus
);
  logic [IDX_W-1:0]  idx;
  logic              we;
  logic [DEPTH-1:0]  valid_q, valid_d;
  logic              hit_q, hit_d;
  logic              flag_q, flag_d;
  logic [DATA_W-1:0] rdata;
  logic              unused_addr;
  assign idx         = bus.addr[IDX_W-1:0];
  assign unused_addr = ^bus.addr[ADDR_W-1:IDX_W];
  assign we          = bus.mode == MODE_WRITE;
  always_comb begin
    valid_d = valid_q;
    if (we) valid_d[idx] = 1'b1;
  end
  // hit_q masks the unreset array output; holding it across writes keeps output_data stable
  assign hit_d  = we ? hit_q : valid_q[idx];
  assign flag_d = we | valid_q[idx];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      hit_q   <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      hit_q   <= hit_d;
      flag_q  <= flag_d;
    end
  end
  mem_array #(.DW(DATA_W), .IW(IDX_W)) u_array (
    .clk     (clk),
    .we_i    (we),
    .re_i    (!we),
    .idx_i   (idx),
    .wdata_i (bus.input_data),
    .rdata_o (rdata)
  );
  assign bus.output_data = hit_q ? rdata : '0;
  assign bus.flag        = flag_q;
endmodule

// File: tb/tb_main_memory.sv
// tb_main_memory: scoreboard-driven checks of main_memory read/write/alias/reset behaviour.
module tb_main_memory;
  import mem_pkg::*;
  typedef struct {
    logic [DATA_W-1:0] d;
    logic              f;
    string             n;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  exp_t q[$];
  logic [DATA_W-1:0] m_mem [int];
  logic [DATA_W-1:0] m_out = '0;
  always #5 clk = ~clk;
  main_memory_if bus ();
  main_memory dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  task automatic op(input string n, input logic w, input logic [31:0] a, input logic [31:0] d);
    int i;
    exp_t e;
    i = int'(a[IDX_W-1:0]);
    @(negedge clk);
    bus.mode = w;
    bus.addr = a;
    bus.input_data = d;
    if (w) begin
      m_mem[i] = d;
      q.push_back('{m_out, 1'b1, n});
    end else begin
      m_out = m_mem.exists(i) ? m_mem[i] : '0;
      q.push_back('{m_out, m_mem.exists(i) ? 1'b1 : 1'b0, n});
    end
    @(posedge clk);
    #1;
    e = q.pop_front();
    checks += 2;
    if (bus.output_data !== e.d) begin
      errors++;
      $display("FAIL %s output_data got %h expected %h", e.n, bus.output_data, e.d);
    end
    if (bus.flag !== e.f) begin
      errors++;
      $display("FAIL %s flag got %b expected %b", e.n, bus.flag, e.f);
    end
  endtask
  task automatic check_zero(input string n);
    checks += 2;
    if (bus.output_data !== '0) begin
      errors++;
      $display("FAIL %s output_data got %h expected 0", n, bus.output_data);
    end
    if (bus.flag !== 1'b0) begin
      errors++;
      $display("FAIL %s flag got %b expected 0", n, bus.flag);
    end
  endtask
  task automatic test_reset();
    repeat (2) @(negedge clk);
    check_zero("reset_state");
    rst_n = 1'b1;
    op("read_after_reset", MODE_READ, 32'd100, 32'd0);
  endtask
  task automatic test_write_read();
    op("write_100", MODE_WRITE, 32'd100, 32'd25);
    op("read_100", MODE_READ, 32'd100, 32'd0);
  endtask
  task automatic test_alias();
    op("read_alias_4196", MODE_READ, 32'd4196, 32'd0);
    op("read_101_empty", MODE_READ, 32'd101, 32'd0);
  endtask
  task automatic test_high_addr();
    op("write_high", MODE_WRITE, 32'd2816867292, 32'hDEADBEEF);
    op("read_3036", MODE_READ, 32'd3036, 32'd0);
    op("read_4095_empty", MODE_READ, 32'd4095, 32'd0);
  endtask
  task automatic test_back_to_back();
    op("write_7", MODE_WRITE, 32'd200, 32'd7);
    op("write_9", MODE_WRITE, 32'd4296, 32'd9);
    op("read_200", MODE_READ, 32'd200, 32'd0);
    op("write_0_hold", MODE_WRITE, 32'd0, 32'h1234_5678);
    op("raw_0", MODE_READ, 32'd0, 32'd0);
    op("read_100_again", MODE_READ, 32'd100, 32'd0);
  endtask
  task automatic test_async_reset();
    op("write_5", MODE_WRITE, 32'd5, 32'd42);
    op("read_5", MODE_READ, 32'd5, 32'd0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_zero("async_reset_outputs");
    m_mem.delete();
    m_out = '0;
    #2;
    rst_n = 1'b1;
    op("read_5_after_reset", MODE_READ, 32'd5, 32'd0);
    op("read_100_after_reset", MODE_READ, 32'd100, 32'd0);
    op("write_after_reset", MODE_WRITE, 32'd5, 32'd43);
    op("read_5_new", MODE_READ, 32'd5, 32'd0);
  endtask
  initial begin
    bus.mode = MODE_READ;
    bus.addr = '0;
    bus.input_data = '0;
    test_reset();
    test_write_read();
    test_alias();
    test_high_addr();
    test_back_to_back();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
